// File: rtl/sodor5_imem_stream_checker.sv
// Receive-side checker for the I-type/load instruction stream on the Sodor5 imem response bus.
// Two-stage pipeline: S1 captures the bus, S2 classifies, counts and latches the first violation.
module sodor5_imem_stream_checker #(
  parameter int unsigned CW     = 16,
  parameter int unsigned WINDOW = 200
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          instr_valid,
  input  logic [31:0]   instr,
  input  logic          clear,
  output logic [CW-1:0] count_nop,
  output logic [CW-1:0] count_alu,
  output logic [CW-1:0] count_load,
  output logic [CW-1:0] count_total,
  output logic          error,
  output logic [2:0]    err_code,
  output logic [31:0]   err_instr,
  output logic [CW-1:0] err_index,
  output logic          done
);

  localparam logic [31:0] NOP_WORD   = 32'h0000_0013;
  localparam logic [6:0]  OP_IMM     = 7'b0010011;
  localparam logic [6:0]  OP_LOAD    = 7'b0000011;
  localparam logic [6:0]  SRA_HI     = 7'b0100000;
  localparam logic [2:0]  ERR_NONE   = 3'd0;
  localparam logic [2:0]  ERR_OPCODE = 3'd1;
  localparam logic [2:0]  ERR_SHAMT  = 3'd2;
  localparam logic [2:0]  ERR_LDF3   = 3'd3;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_ERR  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic          flush;
  logic          s1_valid;
  logic [31:0]   s1_instr;
  logic [6:0]    opcode;
  logic [2:0]    funct3;
  logic [6:0]    imm_hi;
  logic          is_nop;
  logic          is_alu;
  logic          is_load;
  logic [2:0]    viol_code;
  logic          accept;
  logic          upd_nop;
  logic          upd_alu;
  logic          upd_load;
  logic          latch_err;
  logic          window_hit;
  logic [CW-1:0] total_inc;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == '1) ? v : v + CW'(1);
  endfunction

  assign flush = !reset || clear;

  // S1: capture the bus word every cycle; a flush drops anything in flight
  always_ff @(posedge clk) begin
    if (flush) begin
      s1_valid <= 1'b0;
      s1_instr <= '0;
    end else begin
      s1_valid <= instr_valid;
      s1_instr <= instr;
    end
  end

  // S2 decode: classify the S1 word, checks taken in priority order
  always_comb begin
    opcode    = s1_instr[6:0];
    funct3    = s1_instr[14:12];
    imm_hi    = s1_instr[31:25];
    is_nop    = 1'b0;
    is_alu    = 1'b0;
    is_load   = 1'b0;
    viol_code = ERR_NONE;
    if (s1_instr == NOP_WORD) begin
      is_nop = 1'b1;
    end else if (opcode == OP_IMM) begin
      if (funct3 == 3'd1 && imm_hi != 7'd0) begin
        viol_code = ERR_SHAMT;
      end else if (funct3 == 3'd5 && imm_hi != 7'd0 && imm_hi != SRA_HI) begin
        viol_code = ERR_SHAMT;
      end else begin
        is_alu = 1'b1;
      end
    end else if (opcode == OP_LOAD) begin
      if (funct3 == 3'd0 || funct3 == 3'd4) begin
        is_load = 1'b1;
      end else begin
        viol_code = ERR_LDF3;
      end
    end else begin
      viol_code = ERR_OPCODE;
    end
  end

  assign total_inc  = sat_inc(count_total);
  assign window_hit = (WINDOW != 0) && (32'(total_inc) == WINDOW);

  // State register; done tracks the DONE state as a registered output
  always_ff @(posedge clk) begin
    if (flush) begin
      state <= ST_RUN;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= (state_nxt == ST_DONE);
    end
  end

  // Next state: a violation wins over window completion on the same word
  always_comb begin
    state_nxt = state;
    case (state)
      ST_RUN: begin
        if (accept) begin
          if (viol_code != ERR_NONE) begin
            state_nxt = ST_ERR;
          end else if (window_hit) begin
            state_nxt = ST_DONE;
          end
        end
      end
      ST_ERR:  state_nxt = ST_ERR;
      ST_DONE: state_nxt = ST_DONE;
      default: state_nxt = ST_RUN;
    endcase
  end

  // Update enables: only words accepted while running touch the counters
  always_comb begin
    accept    = s1_valid && (state == ST_RUN);
    upd_nop   = 1'b0;
    upd_alu   = 1'b0;
    upd_load  = 1'b0;
    latch_err = 1'b0;
    if (accept) begin
      upd_nop   = is_nop;
      upd_alu   = is_alu;
      upd_load  = is_load;
      latch_err = (viol_code != ERR_NONE);
    end
  end

  // Saturating counters and first-violation capture
  always_ff @(posedge clk) begin
    if (flush) begin
      count_nop   <= '0;
      count_alu   <= '0;
      count_load  <= '0;
      count_total <= '0;
      error       <= 1'b0;
      err_code    <= ERR_NONE;
      err_instr   <= '0;
      err_index   <= '0;
    end else begin
      if (accept) begin
        count_total <= total_inc;
      end
      if (upd_nop) begin
        count_nop <= sat_inc(count_nop);
      end
      if (upd_alu) begin
        count_alu <= sat_inc(count_alu);
      end
      if (upd_load) begin
        count_load <= sat_inc(count_load);
      end
      if (latch_err) begin
        error     <= 1'b1;
        err_code  <= viol_code;
        err_instr <= s1_instr;
        err_index <= count_total;
      end
    end
  end

endmodule
